// File: rtl/wide_proc.sv
// Wide register-file processor: ADD/SUB/LDI/ST/NOP in 1 cycle, LDM 2, MUL DATA_W+1 (only with WIDE_PROC_MUL_EN).
// Backpressure: instr_ready low outside IDLE and during reset; done pulses the cycle after the final register write.
module wide_proc #(
   parameter int DATA_W = 512,
   parameter int NREG   = 4,
   parameter int ADDR_W = 8,
   localparam int REG_W   = $clog2(NREG),
   localparam int INSTR_W = 3 + REG_W + ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [INSTR_W-1:0]       instruction,
   input  logic                     instr_valid,
   output logic                     instr_ready,
   output logic                     done,
   output logic                     illegal,
   output logic [NREG*DATA_W-1:0]   A
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_MUL = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_LDI = 3'b100;
   localparam logic [2:0] OP_LDM = 3'b101;
   localparam logic [2:0] OP_ST  = 3'b110;

`ifdef WIDE_PROC_MUL_EN
   typedef enum logic [1:0] {IDLE, LDM_WAIT, MUL_RUN} state_t;
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   mcand;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W:0]     mul_sum;
   logic [2*DATA_W-1:0] prod_nxt;
`else
   typedef enum logic [1:0] {IDLE, LDM_WAIT} state_t;
`endif

   state_t state, state_nxt;

   logic [DATA_W-1:0] r [NREG];
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rd_q;
   logic [REG_W-1:0]  ldm_sel;

   logic [2:0]        op;
   logic [REG_W-1:0]  rsel;
   logic [ADDR_W-1:0] addr;
   logic              accept;
   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   diff;

   assign op     = instruction[INSTR_W-1 -: 3];
   assign rsel   = instruction[ADDR_W +: REG_W];
   assign addr   = instruction[ADDR_W-1:0];
   assign instr_ready = rst && (state == IDLE);
   assign accept = instr_valid && instr_ready;

   // Extra top bit holds carry (ADD) or borrow (SUB).
   assign sum  = {1'b0, r[0]} + {1'b0, r[1]};
   assign diff = {1'b0, r[0]} - {1'b0, r[1]};

`ifdef WIDE_PROC_MUL_EN
   // One shift-add step: multiplier sits in the low half and shifts out LSB first.
   assign mul_sum  = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, mcand} : {(DATA_W+1){1'b0}});
   assign prod_nxt = {mul_sum, prod[DATA_W-1:1]};
`endif

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept && op == OP_LDM) state_nxt = LDM_WAIT;
`ifdef WIDE_PROC_MUL_EN
            if (accept && op == OP_MUL) state_nxt = MUL_RUN;
`endif
         end
         LDM_WAIT: state_nxt = IDLE;
`ifdef WIDE_PROC_MUL_EN
         MUL_RUN: if (cnt == CNT_LAST) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Memory is deliberately outside reset; a store is visible to a load accepted on the next edge.
   always_ff @(posedge clk) begin
      if (accept && op == OP_ST)  mem[addr] <= r[rsel];
      if (accept && op == OP_LDM) rd_q <= mem[addr];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) r[i] <= '0;
         done    <= 1'b0;
         illegal <= 1'b0;
         ldm_sel <= '0;
`ifdef WIDE_PROC_MUL_EN
         cnt     <= '0;
`endif
      end else begin
         done    <= 1'b0;
         illegal <= 1'b0;
         if (accept) begin
            case (op)
               OP_ADD: begin
                  r[2] <= sum[DATA_W-1:0];
                  r[3] <= {{(DATA_W-1){1'b0}}, sum[DATA_W]};
                  done <= 1'b1;
               end
               OP_SUB: begin
                  r[2] <= diff[DATA_W-1:0];
                  r[3] <= {{(DATA_W-1){1'b0}}, diff[DATA_W]};
                  done <= 1'b1;
               end
               OP_LDI: begin
                  r[rsel] <= DATA_W'(addr);
                  done    <= 1'b1;
               end
               OP_LDM: ldm_sel <= rsel;
               OP_MUL: begin
`ifdef WIDE_PROC_MUL_EN
                  mcand <= r[0];
                  prod  <= {{DATA_W{1'b0}}, r[1]};
                  cnt   <= '0;
`else
                  done    <= 1'b1;
                  illegal <= 1'b1;
`endif
               end
               default: done <= 1'b1;
            endcase
         end
         if (state == LDM_WAIT) begin
            r[ldm_sel] <= rd_q;
            done       <= 1'b1;
         end
`ifdef WIDE_PROC_MUL_EN
         if (state == MUL_RUN) begin
            prod <= prod_nxt;
            cnt  <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
               r[3] <= prod_nxt[2*DATA_W-1:DATA_W];
               r[2] <= prod_nxt[DATA_W-1:0];
               done <= 1'b1;
               cnt  <= '0;
            end
         end
`endif
      end
   end

   for (genvar i = 0; i < NREG; i++) begin : g_out
      assign A[i*DATA_W +: DATA_W] = r[i];
   end

endmodule

// File: tb/tb_wide_proc.sv
// Self-checking bench for wide_proc: table of instructions with expected register files, scoreboard popped on done.
module tb_wide_proc;
   localparam int W = 512;
   localparam logic [2:0] OP_ADD = 3'b000, OP_MUL = 3'b001, OP_SUB = 3'b010, OP_NOP = 3'b011,
                          OP_LDI = 3'b100, OP_LDM = 3'b101, OP_ST = 3'b110, OP_NOP2 = 3'b111;

   typedef logic [3:0][W-1:0] regs_t;
   typedef struct {
      logic [2:0] op;
      logic [1:0] rg;
      logic [7:0] ad;
      regs_t      r;
      bit         ill;
      int         lat;
   } vec_t;
   typedef struct {
      regs_t r;
      bit    ill;
      int    lat;
      int    acc;
      int    tag;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [12:0]   instruction = '0;
   logic          instr_valid = 1'b0;
   logic          instr_ready;
   logic          done;
   logic          illegal;
   logic [4*W-1:0] A;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   exp_t sbq[$];
   exp_t mon_e;
   vec_t tbl[24];

   wide_proc dut (
      .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .done(done), .illegal(illegal), .A(A)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] neg(input int k);
      logic [W-1:0] z;
      z = '0;
      return z - W'(k);
   endfunction

   function automatic regs_t rv(input logic [W-1:0] a, b, c, d);
      regs_t t;
      t[0] = a; t[1] = b; t[2] = c; t[3] = d;
      return t;
   endfunction

   function automatic vec_t mk(input logic [2:0] op, input logic [1:0] rg, input logic [7:0] ad,
                               input regs_t r, input bit ill, input int lat);
      vec_t v;
      v.op = op; v.rg = rg; v.ad = ad; v.r = r; v.ill = ill; v.lat = lat;
      return v;
   endfunction

   task automatic chk_w(input string nm, input int tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s #%0d got=%h want=%h", nm, tag, act, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s #%0d got=%0d want=%0d", nm, tag, act, exp);
      end
   endtask

   task automatic chk_regs(input string nm, input int tag, input regs_t exp);
      for (int i = 0; i < 4; i++) chk_w(nm, tag * 10 + i, A[i*W +: W], exp[i]);
   endtask

   // Waits (bounded) for ready, presents the instruction for one accept edge, optionally queues the expectation.
   task automatic issue(input logic [2:0] op, input logic [1:0] rg, input logic [7:0] ad,
                        input regs_t er, input bit ill, input int lat, input int tag, input bit push);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!instr_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout #%0d got=0 want=1", tag);
      end else begin
         instruction = {op, rg, ad};
         instr_valid = 1'b1;
         @(posedge clk);
         #1;
         instr_valid = 1'b0;
         if (push) begin
            e.r = er; e.ill = ill; e.lat = lat; e.acc = cyc; e.tag = tag;
            sbq.push_back(e);
         end
      end
   endtask

   task automatic busy_len(input string nm, input int tag, input int exp);
      int n;
      n = 0;
      @(negedge clk);
      while (!instr_ready && n < W + 50) begin
         n++;
         @(negedge clk);
      end
      chk_i(nm, tag, n, exp);
   endtask

   always @(negedge clk) begin
      if (done) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done cycle=%0d got=1 want=0", cyc);
         end else begin
            mon_e = sbq.pop_front();
            chk_regs("regs", mon_e.tag, mon_e.r);
            chk_i("illegal", mon_e.tag, int'(illegal), int'(mon_e.ill));
            chk_i("latency", mon_e.tag, cyc - mon_e.acc, mon_e.lat);
         end
      end else if (illegal) begin
         checks++;
         failures++;
         $display("FAIL illegal_without_done cycle=%0d got=1 want=0", cyc);
      end
   end

   initial begin
      regs_t z;
      z = rv('0, '0, '0, '0);
      tbl[0]  = mk(OP_LDI, 0, 200, rv(200, 0, 0, 0), 0, 0);
      tbl[1]  = mk(OP_LDI, 1, 100, rv(200, 100, 0, 0), 0, 0);
      tbl[2]  = mk(OP_ADD, 0, 0,   rv(200, 100, 300, 0), 0, 0);
      tbl[3]  = mk(OP_LDI, 0, 100, rv(100, 100, 300, 0), 0, 0);
      tbl[4]  = mk(OP_LDI, 1, 200, rv(100, 200, 300, 0), 0, 0);
      tbl[5]  = mk(OP_SUB, 0, 0,   rv(100, 200, neg(100), 1), 0, 0);
      tbl[6]  = mk(OP_ST,  2, 7,   rv(100, 200, neg(100), 1), 0, 0);
      tbl[7]  = mk(OP_LDM, 0, 7,   rv(neg(100), 200, neg(100), 1), 0, 1);
      tbl[8]  = mk(OP_ADD, 0, 0,   rv(neg(100), 200, 100, 1), 0, 0);
      tbl[9]  = mk(OP_SUB, 0, 0,   rv(neg(100), 200, neg(300), 0), 0, 0);
      tbl[10] = mk(OP_NOP, 2, 9,   rv(neg(100), 200, neg(300), 0), 0, 0);
      tbl[11] = mk(OP_NOP2, 1, 3,  rv(neg(100), 200, neg(300), 0), 0, 0);
      tbl[12] = mk(OP_LDI, 2, 12,  rv(neg(100), 200, 12, 0), 0, 0);
      tbl[13] = mk(OP_ST,  2, 5,   rv(neg(100), 200, 12, 0), 0, 0);
      tbl[14] = mk(OP_LDM, 1, 5,   rv(neg(100), 12, 12, 0), 0, 1);
      tbl[15] = mk(OP_LDI, 3, 255, rv(neg(100), 12, 12, 255), 0, 0);
      tbl[16] = mk(OP_LDM, 2, 7,   rv(neg(100), 12, neg(100), 255), 0, 1);
      tbl[17] = mk(OP_SUB, 0, 0,   rv(neg(100), 12, neg(112), 0), 0, 0);
      tbl[18] = mk(OP_LDI, 1, 0,   rv(neg(100), 0, neg(112), 0), 0, 0);
      tbl[19] = mk(OP_ADD, 0, 0,   rv(neg(100), 0, neg(100), 0), 0, 0);
      tbl[20] = mk(OP_ST,  0, 255, rv(neg(100), 0, neg(100), 0), 0, 0);
      tbl[21] = mk(OP_LDM, 3, 255, rv(neg(100), 0, neg(100), neg(100)), 0, 1);
      tbl[22] = mk(OP_LDI, 0, 255, rv(255, 0, neg(100), neg(100)), 0, 0);
      tbl[23] = mk(OP_SUB, 0, 0,   rv(255, 0, 255, 0), 0, 0);

      // Reset state
      repeat (3) @(negedge clk);
      chk_i("ready_in_reset", 0, int'(instr_ready), 0);
      chk_regs("reset_regs", 0, z);
      chk_i("done_in_reset", 0, int'(done), 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_i("ready_after_release", 0, int'(instr_ready), 1);

      foreach (tbl[i]) issue(tbl[i].op, tbl[i].rg, tbl[i].ad, tbl[i].r, tbl[i].ill, tbl[i].lat, 100 + i, 1'b1);

`ifdef WIDE_PROC_MUL_EN
      issue(OP_LDI, 0, 3, rv(3, 0, 255, 0), 0, 0, 200, 1'b1);
      issue(OP_LDI, 1, 4, rv(3, 4, 255, 0), 0, 0, 201, 1'b1);
      issue(OP_MUL, 0, 0, rv(3, 4, 12, 0), 0, W, 202, 1'b1);
      busy_len("mul_busy", 202, W);
      issue(OP_LDM, 0, 7, rv(neg(100), 4, 12, 0), 0, 1, 203, 1'b1);
      issue(OP_LDM, 1, 7, rv(neg(100), neg(100), 12, 0), 0, 1, 204, 1'b1);
      issue(OP_MUL, 0, 0, rv(neg(100), neg(100), 10000, neg(200)), 0, W, 205, 1'b1);
      issue(OP_LDI, 2, 12, rv(neg(100), neg(100), 12, neg(200)), 0, 0, 206, 1'b1);
      issue(OP_ST, 2, 5, rv(neg(100), neg(100), 12, neg(200)), 0, 0, 207, 1'b1);
      issue(OP_LDM, 0, 5, rv(12, neg(100), 12, neg(200)), 0, 1, 208, 1'b1);
      busy_len("ldm_busy", 208, 1);
      // Abort a multiply in flight.
      issue(OP_MUL, 0, 0, z, 0, 0, 300, 1'b0);
      repeat (100) @(negedge clk);
      rst = 1'b0;
`else
      issue(OP_MUL, 2, 0, rv(255, 0, 255, 0), 1, 0, 200, 1'b1);
      issue(OP_LDI, 2, 12, rv(255, 0, 12, 0), 0, 0, 206, 1'b1);
      issue(OP_ST, 2, 5, rv(255, 0, 12, 0), 0, 0, 207, 1'b1);
      issue(OP_LDM, 0, 5, rv(12, 0, 12, 0), 0, 1, 208, 1'b1);
      busy_len("ldm_busy", 208, 1);
      // Abort a load in flight.
      issue(OP_LDM, 1, 5, z, 0, 0, 300, 1'b0);
      rst = 1'b0;
`endif
      @(posedge clk);
      #1;
      chk_i("ready_in_abort_reset", 300, int'(instr_ready), 0);
      chk_regs("abort_regs", 300, z);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_i("ready_after_abort", 300, int'(instr_ready), 1);
      repeat (W + 20) @(negedge clk);
      chk_regs("abort_regs_late", 301, z);

      // Memory survives reset.
      issue(OP_LDM, 0, 5, rv(12, 0, 0, 0), 0, 1, 400, 1'b1);
      repeat (5) @(negedge clk);
      chk_i("scoreboard_empty", 500, sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
